kbd_scan_ctrl: RTL

- Scan-code sequencer behind the PS/2 bit receiver.
- Consumes validated bytes (byte + one-cycle strobe) and decodes Set-2 prefixes: E0 extended, F0 break, E1 pause.
- Emits make/break key events through a small valid/ready FIFO.
- Maintains a pressed-state bitmap for the game's tracked keys, which the game logic reads directly.

---
 rtl/kbd_pkg.sv | 38 +++
 rtl/kbd_evt_fifo.sv | 46 ++++
 rtl/kbd_scan_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/kbd_pkg.sv
// rtl/kbd_pkg.sv - Set-2 byte constants, FSM encoding, event record and tracked-key table
// shared by the scan-code sequencer and its event FIFO.
package kbd_pkg;

  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_F0 = 8'hF0;
  localparam logic [7:0] SC_E1 = 8'hE1;
  localparam logic [7:0] SC_AA = 8'hAA;
  localparam logic [7:0] SC_00 = 8'h00;
  localparam logic [7:0] SC_FF = 8'hFF;
  localparam logic [7:0] SC_12 = 8'h12;
  localparam logic [7:0] SC_59 = 8'h59;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_SKIP
  } kbd_state_t;

  typedef struct packed {
    logic       ext;
    logic [7:0] code;
    logic       make;
  } kbd_evt_t;

  // Order fixes the key_down bit index: left, right, up, down, space, enter, esc, P.
  localparam int unsigned KEY_TABLE_LEN = 8;
  localparam logic [8:0] KEY_TABLE [KEY_TABLE_LEN] = '{
    9'h16B, 9'h174, 9'h175, 9'h172, 9'h029, 9'h05A, 9'h076, 9'h04D
  };

  function automatic logic is_fake_shift(input logic [7:0] b);
    return (b == SC_12) || (b == SC_59);
  endfunction

endpackage

// File: rtl/kbd_evt_fifo.sv
// rtl/kbd_evt_fifo.sv - Synchronous event FIFO: plain write port, valid/ready read side.
// A write while full is accepted only when the head is popped in the same cycle.
module kbd_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tvalid,
  input  logic             i_tready,
  output logic             o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_pop;
  logic             w_push;

  assign o_tvalid = (r_wr_ptr != r_rd_ptr);
  assign o_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop    = o_tvalid && i_tready;
  assign w_push   = i_wr_en && (!o_full || w_pop);
  assign o_tdata  = o_tvalid ? r_mem[r_rd_ptr[AW-1:0]] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

endmodule

// File: rtl/kbd_scan_ctrl.sv
// rtl/kbd_scan_ctrl.sv - Set-2 prefix decoder feeding make/break events and a held-key bitmap.
// Define KBD_TYPEMATIC_FILTER_EN to drop auto-repeat makes of already-held tracked keys.
module kbd_scan_ctrl import kbd_pkg::*; #(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 50000,
  parameter int NUM_KEYS    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          din,
  input  logic                din_new,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [8:0]          evt_code,
  output logic                evt_make,
  output logic [NUM_KEYS-1:0] key_down,
  output logic                seq_err,
  output logic                ovf,
  input  logic                ovf_clr
);

  localparam int             CW      = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT_CYC - 1);

  kbd_state_t          r_state;
  kbd_state_t          w_next;
  logic [CW-1:0]       r_to_cnt;
  logic [2:0]          r_skip;
  logic [NUM_KEYS-1:0] r_key_down;
  logic [NUM_KEYS-1:0] w_match;
  logic                r_seq_err;
  logic                r_ovf;
  logic                w_timeout;
  logic                w_emit;
  logic                w_wr;
  logic                w_err;
  logic                w_clr_keys;
  logic                w_full;
  logic                w_drop;
  kbd_evt_t            w_evt;
  kbd_evt_t            w_head;

  // A byte on the expiry cycle takes precedence over the timeout.
  assign w_timeout = (r_state != ST_IDLE) && !din_new && (r_to_cnt == TO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (din_new) begin
      case (r_state)
        ST_IDLE: begin
          if (din == SC_E0)      w_next = ST_EXT;
          else if (din == SC_F0) w_next = ST_BRK;
          else if (din == SC_E1) w_next = ST_SKIP;
        end
        ST_EXT:  w_next = (din == SC_F0) ? ST_EXT_BRK : ST_IDLE;
        ST_SKIP: if (r_skip == 3'd1) w_next = ST_IDLE;
        default: w_next = ST_IDLE;
      endcase
    end else if (w_timeout) begin
      w_next = ST_IDLE;
    end
  end

  always_comb begin
    w_emit     = 1'b0;
    w_err      = w_timeout;
    w_clr_keys = 1'b0;
    w_evt.ext  = 1'b0;
    w_evt.code = din;
    w_evt.make = 1'b1;
    if (din_new) begin
      case (r_state)
        ST_IDLE: begin
          if (din == SC_00 || din == SC_FF) begin
            w_err      = 1'b1;
            w_clr_keys = 1'b1;
          end else if (din != SC_E0 && din != SC_F0 && din != SC_E1 && din != SC_AA) begin
            w_emit = 1'b1;
          end
        end
        ST_EXT: begin
          w_evt.ext = 1'b1;
          w_emit    = (din != SC_F0) && !is_fake_shift(din);
        end
        ST_BRK: begin
          w_evt.make = 1'b0;
          w_emit     = 1'b1;
        end
        ST_EXT_BRK: begin
          w_evt.ext  = 1'b1;
          w_evt.make = 1'b0;
          w_emit     = !is_fake_shift(din);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_KEYS; i++) begin
      w_match[i] = ({w_evt.ext, w_evt.code} == KEY_TABLE[i]);
    end
  end

`ifdef KBD_TYPEMATIC_FILTER_EN
  assign w_wr = w_emit && !(w_evt.make && |(w_match & r_key_down));
`else
  assign w_wr = w_emit;
`endif

  assign w_drop = w_wr && w_full && !(evt_valid && evt_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                     r_to_cnt <= '0;
    else if (r_state == ST_IDLE || din_new || w_timeout) r_to_cnt <= '0;
    else                                           r_to_cnt <= r_to_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_skip <= '0;
    end else if (din_new) begin
      if (r_state == ST_IDLE && din == SC_E1) r_skip <= 3'd7;
      else if (r_state == ST_SKIP)            r_skip <= r_skip - 1'b1;
    end
  end

  // key_down tracks every decoded event, even ones the FIFO cannot hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_key_down <= '0;
    end else if (w_clr_keys) begin
      r_key_down <= '0;
    end else if (w_emit) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (w_match[i]) r_key_down[i] <= w_evt.make;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seq_err <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_seq_err <= w_err;
      if (ovf_clr)     r_ovf <= 1'b0;
      else if (w_drop) r_ovf <= 1'b1;
    end
  end

  kbd_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(kbd_evt_t))
  ) u_fifo (
    .clk       (clk),
    .rst       (reset),
    .i_wr_en   (w_wr),
    .i_wr_data (w_evt),
    .o_tdata   (w_head),
    .o_tvalid  (evt_valid),
    .i_tready  (evt_ready),
    .o_full    (w_full)
  );

  assign evt_code = {w_head.ext, w_head.code};
  assign evt_make = w_head.make;
  assign key_down = r_key_down;
  assign seq_err  = r_seq_err;
  assign ovf      = r_ovf;

endmodule
